mem_simple_dual_port_init: RTL and testbench

//  Simple dual-port RAM, successor generation: one write port (A), one read port (B), single clock.

---
 rtl/mem_simple_dual_port_init_pkg.sv | 21 ++
 rtl/mem_simple_dual_port_init_if.sv | 24 ++
 rtl/mem_simple_dual_port_init_sequencer.sv | 51 +++++
 rtl/mem_simple_dual_port_init.sv | 114 +++++++++++
 tb/tb_mem_simple_dual_port_init.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_simple_dual_port_init_pkg.sv
// Shared types and the lane-merge helper for the simple dual-port RAM with init sequencer.
package mem_pkg;

   localparam int MEM_MAX_W = 1024;

   typedef enum logic {INIT_CLEAR, INIT_IDLE} init_state_t;

   typedef logic [MEM_MAX_W-1:0] mem_word_t;

   // Replace the lanes of old_w selected by we with the matching lanes of new_w.
   function automatic mem_word_t lane_merge(input mem_word_t old_w, input mem_word_t new_w,
                                            input mem_word_t we, input int lane_w);
      mem_word_t res;
      res = old_w;
      for (int i = 0; i < MEM_MAX_W; i++) begin
         if (we[i / lane_w]) res[i] = new_w[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_simple_dual_port_init_if.sv
// Port A write / port B read bundle plus the clear/busy control pair.
interface mem_simple_dual_port_init_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LANE_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int ADDR_W    = $clog2(DEPTH);

   logic                  clear;
   logic                  busy;
   logic [NUM_LANES-1:0]  wea;
   logic [ADDR_W-1:0]     addra;
   logic [DATA_WIDTH-1:0] dia;
   logic                  reb;
   logic [ADDR_W-1:0]     addrb;
   logic [DATA_WIDTH-1:0] dob;
   logic                  dob_valid;

   modport master (output clear, wea, addra, dia, reb, addrb,
                   input  busy, dob, dob_valid);
   modport slave  (input  clear, wea, addra, dia, reb, addrb,
                   output busy, dob, dob_valid);
endinterface

// File: rtl/mem_simple_dual_port_init_sequencer.sv
// Init sweep FSM: walks ptr over every entry after reset or clear, owning the write port meanwhile.
module mem_init_sequencer
   import mem_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   output logic              busy,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   init_state_t       state_d, state_q;
   logic [ADDR_W-1:0] ptr_d, ptr_q;

   // clear wins over the end-of-sweep wrap so a late clear still restarts from 0.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (clear) begin
         state_d = INIT_CLEAR;
         ptr_d   = '0;
      end else if (state_q == INIT_CLEAR) begin
         if (ptr_q == LAST) begin
            state_d = INIT_IDLE;
            ptr_d   = '0;
         end else begin
            ptr_d = ptr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign busy      = (state_q == INIT_CLEAR);
   assign init_we   = busy;
   assign init_addr = ptr_q;

endmodule

// File: rtl/mem_simple_dual_port_init.sv
// Simple dual-port RAM with byte-lane writes, read bypass, 0/1/2-cycle read pipeline and init sweep.
module mem_simple_dual_port_init
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int LANE_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int OUTPUT_DELAY  = 1,
   parameter int WRITE_FIRST   = 1,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
   input logic                       clk,
   input logic                       reset_n,
   mem_simple_dual_port_init_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);

   if (OUTPUT_DELAY < 0 || OUTPUT_DELAY > 2) begin : g_bad_delay
      $fatal(1, "OUTPUT_DELAY must be 0, 1 or 2");
   end
   if (LANE_WIDTH < 1 || DATA_WIDTH % LANE_WIDTH != 0 || DATA_WIDTH > MEM_MAX_W) begin : g_bad_width
      $fatal(1, "DATA_WIDTH must be a multiple of LANE_WIDTH");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "DEPTH must be at least 2");
   end

   logic                  busy;
   logic                  init_we;
   logic [ADDR_W-1:0]     init_addr;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] wr_word;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  wr_ok;
   logic                  rd_in_range;

   mem_init_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (bus.clear),
      .busy      (busy),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   assign bus.busy = busy;

   always_comb begin
      wr_ok       = !busy && (int'(bus.addra) < DEPTH) && (|bus.wea);
      rd_in_range = int'(bus.addrb) < DEPTH;
      rd_word     = rd_in_range ? mem_q[bus.addrb] : DEFAULT_VALUE;
      wr_word     = DATA_WIDTH'(lane_merge(MEM_MAX_W'(mem_q[bus.addra]), MEM_MAX_W'(bus.dia),
                                           MEM_MAX_W'(bus.wea), LANE_WIDTH));
   end

   // The sweep owns the write port while busy; port A is simply not looked at then.
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem_q[init_addr] <= DEFAULT_VALUE;
      end else if (wr_ok) begin
         mem_q[bus.addra] <= wr_word;
      end
   end

   if (OUTPUT_DELAY == 0) begin : g_d0
      assign bus.dob       = rd_word;
      assign bus.dob_valid = bus.reb;
   end else begin : g_dn
      logic                  byp_hit;
      logic [DATA_WIDTH-1:0] byp_word;
      logic [DATA_WIDTH-1:0] s1_d, s1_q;
      logic                  v1_q;

      always_comb begin
         byp_hit  = (WRITE_FIRST != 0) && !busy && rd_in_range && (bus.addra == bus.addrb);
         byp_word = byp_hit ? DATA_WIDTH'(lane_merge(MEM_MAX_W'(rd_word), MEM_MAX_W'(bus.dia),
                                                     MEM_MAX_W'(bus.wea), LANE_WIDTH))
                            : rd_word;
         s1_d     = bus.reb ? byp_word : s1_q;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s1_q <= DEFAULT_VALUE;
            v1_q <= 1'b0;
         end else begin
            s1_q <= s1_d;
            v1_q <= bus.reb;
         end
      end

      if (OUTPUT_DELAY == 1) begin : g_d1
         assign bus.dob       = s1_q;
         assign bus.dob_valid = v1_q;
      end else begin : g_d2
         logic [DATA_WIDTH-1:0] s2_q;
         logic                  v2_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s2_q <= DEFAULT_VALUE;
               v2_q <= 1'b0;
            end else begin
               s2_q <= s1_q;
               v2_q <= v1_q;
            end
         end

         assign bus.dob       = s2_q;
         assign bus.dob_valid = v2_q;
      end
   end

endmodule

// File: tb/tb_mem_simple_dual_port_init.sv
// Directed bench for three RAM configurations: delay 1 / write-first, delay 2 / read-first, delay 0.
module tb_mem_simple_dual_port_init;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_simple_dual_port_init_if #(.DATA_WIDTH(8),  .LANE_WIDTH(8), .DEPTH(16)) if0 ();
   mem_simple_dual_port_init_if #(.DATA_WIDTH(16), .LANE_WIDTH(8), .DEPTH(12)) if1 ();
   mem_simple_dual_port_init_if #(.DATA_WIDTH(8),  .LANE_WIDTH(8), .DEPTH(5))  if2 ();

   mem_simple_dual_port_init #(.DATA_WIDTH(8), .LANE_WIDTH(8), .DEPTH(16), .OUTPUT_DELAY(1),
      .WRITE_FIRST(1), .DEFAULT_VALUE(8'h00)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
   mem_simple_dual_port_init #(.DATA_WIDTH(16), .LANE_WIDTH(8), .DEPTH(12), .OUTPUT_DELAY(2),
      .WRITE_FIRST(0), .DEFAULT_VALUE(16'h0000)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
   mem_simple_dual_port_init #(.DATA_WIDTH(8), .LANE_WIDTH(8), .DEPTH(5), .OUTPUT_DELAY(0),
      .WRITE_FIRST(1), .DEFAULT_VALUE(8'hA5)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

   typedef struct {
      logic [1:0]  wea;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;

   vec_t t0 [5];
   vec_t t1 [5];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic wr0(input logic we, input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      if0.wea = we; if0.addra = a; if0.dia = d;
      @(negedge clk);
      if0.wea = 1'b0;
   endtask

   task automatic rd0(input logic [3:0] a, input logic [7:0] exp, input string nm);
      @(negedge clk);
      if0.reb = 1'b1; if0.addrb = a;
      @(negedge clk);
      chk({nm, " dob"}, 32'(if0.dob), 32'(exp));
      chk({nm, " vld"}, 32'(if0.dob_valid), 32'd1);
      if0.reb = 1'b0;
      @(negedge clk);
      chk({nm, " vld_drop"}, 32'(if0.dob_valid), 32'd0);
   endtask

   task automatic wr1(input logic [1:0] we, input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      if1.wea = we; if1.addra = a; if1.dia = d;
      @(negedge clk);
      if1.wea = 2'b00;
   endtask

   task automatic rd1(input logic [3:0] a, input logic [15:0] exp, input string nm);
      @(negedge clk);
      if1.reb = 1'b1; if1.addrb = a;
      @(negedge clk);
      if1.reb = 1'b0;
      chk({nm, " vld_early"}, 32'(if1.dob_valid), 32'd0);
      @(negedge clk);
      chk({nm, " dob"}, 32'(if1.dob), 32'(exp));
      chk({nm, " vld"}, 32'(if1.dob_valid), 32'd1);
      @(negedge clk);
      chk({nm, " vld_drop"}, 32'(if1.dob_valid), 32'd0);
      chk({nm, " dob_hold"}, 32'(if1.dob), 32'(exp));
   endtask

   task automatic busy_len1(input string nm);
      int n = 0;
      while (if1.busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, 32'(n), 32'd12);
   endtask

   initial begin
      int f0, f1, f2, n;
      logic [15:0] d;

      if0.clear = 0; if0.wea = 0; if0.addra = 0; if0.dia = 0; if0.reb = 0; if0.addrb = 0;
      if1.clear = 0; if1.wea = 0; if1.addra = 0; if1.dia = 0; if1.reb = 0; if1.addrb = 0;
      if2.clear = 0; if2.wea = 0; if2.addra = 0; if2.dia = 0; if2.reb = 0; if2.addrb = 0;

      t0[0] = '{2'b01, 4'd3,  16'h003C, 16'h003C};
      t0[1] = '{2'b00, 4'd4,  16'h00FF, 16'h0000};
      t0[2] = '{2'b01, 4'd15, 16'h00E1, 16'h00E1};
      t0[3] = '{2'b01, 4'd0,  16'h0081, 16'h0081};
      t0[4] = '{2'b01, 4'd3,  16'h0044, 16'h0044};
      t1[0] = '{2'b01, 4'd3,  16'hABCD, 16'h00CD};
      t1[1] = '{2'b10, 4'd3,  16'h1234, 16'h12CD};
      t1[2] = '{2'b11, 4'd11, 16'hBEEF, 16'hBEEF};
      t1[3] = '{2'b11, 4'd12, 16'h1111, 16'h0000};
      t1[4] = '{2'b00, 4'd11, 16'hFFFF, 16'hBEEF};

      repeat (3) @(negedge clk);
      chk("rst u0 busy", 32'(if0.busy), 32'd1);
      chk("rst u0 vld", 32'(if0.dob_valid), 32'd0);
      chk("rst u0 dob", 32'(if0.dob), 32'h00);
      chk("rst u1 vld", 32'(if1.dob_valid), 32'd0);
      chk("rst u1 dob", 32'(if1.dob), 32'h0000);

      reset_n = 1'b1;
      f0 = 0; f1 = 0; f2 = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (f0 == 0 && !if0.busy) f0 = e;
         if (f1 == 0 && !if1.busy) f1 = e;
         if (f2 == 0 && !if2.busy) f2 = e;
      end
      chk("sweep len u0", 32'(f0), 32'd16);
      chk("sweep len u1", 32'(f1), 32'd12);
      chk("sweep len u2", 32'(f2), 32'd5);

      for (int a = 0; a < 16; a++) rd0(a[3:0], 8'h00, $sformatf("u0 sweep rd%0d", a));

      for (int i = 0; i < 5; i++) begin
         wr0(t0[i].wea[0], t0[i].addr, t0[i].data[7:0]);
         rd0(t0[i].addr, t0[i].exp[7:0], $sformatf("u0 vec%0d", i));
      end

      // Same-cycle write/read to addr 5 on the write-first instance.
      @(negedge clk);
      if0.wea = 1'b1; if0.addra = 4'd5; if0.dia = 8'h55; if0.reb = 1'b1; if0.addrb = 4'd5;
      @(negedge clk);
      chk("u0 wf bypass dob", 32'(if0.dob), 32'h55);
      chk("u0 wf bypass vld", 32'(if0.dob_valid), 32'd1);
      if0.wea = 1'b0; if0.reb = 1'b0; if0.addrb = 4'd3;
      repeat (2) @(negedge clk);
      chk("u0 stage1 hold", 32'(if0.dob), 32'h55);
      rd0(4'd5, 8'h55, "u0 wf commit");

      for (int i = 0; i < 5; i++) begin
         wr1(t1[i].wea, t1[i].addr, t1[i].data);
         rd1(t1[i].addr, t1[i].exp, $sformatf("u1 vec%0d", i));
      end

      // Same-cycle write/read on the read-first instance returns the old word.
      @(negedge clk);
      if1.wea = 2'b11; if1.addra = 4'd5; if1.dia = 16'h0055; if1.reb = 1'b1; if1.addrb = 4'd5;
      @(negedge clk);
      if1.wea = 2'b00; if1.reb = 1'b0;
      @(negedge clk);
      chk("u1 rf old dob", 32'(if1.dob), 32'h0000);
      chk("u1 rf old vld", 32'(if1.dob_valid), 32'd1);
      rd1(4'd5, 16'h0055, "u1 rf commit");

      for (int a = 0; a < 12; a++) begin
         d = 16'h1111 * 16'(a + 1);
         wr1(2'b11, a[3:0], d);
      end
      rd1(4'd7, 16'h8888, "u1 fill rd");
      @(negedge clk); if1.clear = 1'b1;
      @(posedge clk); #1; if1.clear = 1'b0;
      chk("u1 clear busy", 32'(if1.busy), 32'd1);
      busy_len1("u1 clear len");
      for (int a = 0; a < 13; a++) rd1(a[3:0], 16'h0000, $sformatf("u1 cleared rd%0d", a));

      for (int a = 0; a < 12; a++) wr1(2'b11, a[3:0], 16'hC3C3);
      @(negedge clk); if1.clear = 1'b1;
      @(posedge clk); #1; if1.clear = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("u1 mid sweep busy", 32'(if1.busy), 32'd1);
      @(negedge clk); if1.clear = 1'b1;
      @(posedge clk); #1; if1.clear = 1'b0;
      busy_len1("u1 restart len");
      rd1(4'd0, 16'h0000, "u1 restart rd0");
      rd1(4'd5, 16'h0000, "u1 restart rd5");
      rd1(4'd11, 16'h0000, "u1 restart rd11");

      @(negedge clk);
      if2.reb = 1'b1; if2.addrb = 3'd3;
      #1;
      chk("u2 comb dob", 32'(if2.dob), 32'hA5);
      chk("u2 comb vld", 32'(if2.dob_valid), 32'd1);
      if2.reb = 1'b0;
      #1;
      chk("u2 comb vld low", 32'(if2.dob_valid), 32'd0);
      @(negedge clk);
      if2.wea = 1'b1; if2.addra = 3'd2; if2.dia = 8'h3C; if2.reb = 1'b1; if2.addrb = 3'd2;
      #1;
      chk("u2 same cycle old", 32'(if2.dob), 32'hA5);
      @(posedge clk); #1;
      if2.wea = 1'b0; if2.reb = 1'b0;
      chk("u2 after write", 32'(if2.dob), 32'h3C);
      @(negedge clk);
      if2.wea = 1'b1; if2.addra = 3'd6; if2.dia = 8'h11;
      @(negedge clk);
      if2.wea = 1'b0; if2.addrb = 3'd6;
      #1;
      chk("u2 oob read", 32'(if2.dob), 32'hA5);
      if2.addrb = 3'd1;
      #1;
      chk("u2 oob no alias", 32'(if2.dob), 32'hA5);

      // clear and read together, then async reset in the middle of the sweep and read stream.
      wr0(1'b1, 4'd7, 8'h77);
      @(negedge clk);
      if0.reb = 1'b1; if0.addrb = 4'd7; if0.clear = 1'b1;
      @(posedge clk); #1;
      if0.clear = 1'b0;
      chk("u0 clear+rd dob", 32'(if0.dob), 32'h77);
      chk("u0 clear+rd busy", 32'(if0.busy), 32'd1);
      if0.wea = 1'b1; if0.addra = 4'd0; if0.dia = 8'hEE;
      repeat (3) @(posedge clk);
      #2;
      chk("u0 pre-rst vld", 32'(if0.dob_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("u0 async rst vld", 32'(if0.dob_valid), 32'd0);
      chk("u0 async rst busy", 32'(if0.busy), 32'd1);
      chk("u0 async rst dob", 32'(if0.dob), 32'h00);
      if0.reb = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      while (if0.busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if0.wea = 1'b0;
      chk("u0 rerun len", 32'(n), 32'd16);
      rd0(4'd0, 8'h00, "u0 busy wea ignored");
      rd0(4'd7, 8'h00, "u0 rerun swept");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
